bb_sync_filter: RTL and testbench
=================================

// Module: bb_sync_filter
// PURPOSE
//   Multi-channel level synchroniser with per-channel glitch filter and edge-event outputs.
//   Each async input passes a STAGE_NUM-deep flop chain, then a stability filter.
//   Each channel produces a clean level, 1-cycle rise/fall pulses and a sticky event flag.
//   Sits at chip/IP boundaries for async status, interrupt and strap lines entering the clk domain.
// PARAMETERS
//   CH_NUM    4    number of independent channels (>=1)
//   STAGE_NUM 2    synchroniser depth per channel (>=2)
//   FILT_CNT  4    consecutive cycles a new synced value must hold before acceptance (>=1)
//   RST_VAL   'b0  CH_NUM-bit reset level per channel (sync stages and gen_signal)
//   localparam CW = $clog2(FILT_CNT+1), filter counter width
// PORTS
//   clk         in   1       single clock; all state in this domain
//   rst_n       in   1       synchronous, active-low reset
//   src_signal  in   CH_NUM  async input levels
//   clr_evt     in   CH_NUM  per-channel sticky-flag clear, level, sampled each cycle
//   gen_signal  out  CH_NUM  synchronised, filtered level (registered)
//   rise_pulse  out  CH_NUM  1-cycle pulse when gen_signal[i] goes 0->1
//   fall_pulse  out  CH_NUM  1-cycle pulse when gen_signal[i] goes 1->0
//   evt_sticky  out  CH_NUM  set on any gen_signal[i] change; held until cleared
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge):
//     - sync stages and gen_signal <= RST_VAL; cnt <= 0; pulses <= 0; evt_sticky <= 0.
//     - No async reset path.
//   - Channels are fully independent. No cross-channel coherency is guaranteed.
//   - Sync chain: s_i = last stage. Stage 1 samples src_signal[i] every edge.
//   - Filter, per edge, s_i compared to gen_signal[i]:
//     - s_i == gen: cnt <= 0.
//     - s_i != gen and cnt < FILT_CNT-1: cnt <= cnt+1.
//     - s_i != gen and cnt == FILT_CNT-1: gen <= s_i, cnt <= 0.
//   - Glitch rejection: any return of s_i to gen before acceptance zeroes cnt. No output effect.
//   - FILT_CNT=1: gen follows s_i with exactly one cycle of delay.
//   - Latency: src held stable from before edge k -> gen updates at edge k+STAGE_NUM+FILT_CNT-1.
//     This is STAGE_NUM+FILT_CNT edges, inclusive of edge k.
//   - Pulses are registered at the same edge as gen, so the pulse is coincident with the new gen value.
//     - rise_pulse = new gen & ~old gen. fall_pulse = ~new gen & old gen.
//     - At most one of rise/fall is high per channel per cycle.
//     - Back-to-back acceptances cannot occur closer than FILT_CNT cycles.
//   - evt_sticky[i] next-state priority:
//     1. Acceptance this edge -> 1. Set wins over a simultaneous clr_evt[i].
//     2. Else clr_evt[i] -> 0.
//     3. Else hold.
//   - Reset release with src != RST_VAL: no pulse at release.
//     The change is reported only after the full sync + filter latency.
//   - Reset asserted mid-filter: in-progress count is discarded. No pulse is produced by the reset itself.
//   - cnt never exceeds FILT_CNT-1. No wrap-around is possible.
// TESTING (CH_NUM=4, STAGE_NUM=2, FILT_CNT=4, RST_VAL=4'b0010 unless stated)
//   1. Reset check:
//      - Hold rst_n=0 3 cycles, src=4'hF.
//      - Expect gen=4'b0010, pulses=0, evt_sticky=0, throughout and for 5 cycles after release.
//   2. Clean rise on ch0:
//      - src[0] 0->1 before edge k, held.
//      - Expect gen[0]=1 after edge k+5, rise_pulse[0]=1 for that cycle only, evt_sticky[0]=1.
//      - Channels 1..3 unchanged.
//   3. Filter boundary on ch3:
//      - 3-cycle high glitch -> no gen/pulse/sticky change.
//      - 4-cycle high pulse -> gen[3]=1 for exactly 4 cycles, one rise_pulse[3], then one fall_pulse[3].
//   4. Sticky priority on ch1:
//      - clr_evt[1]=1 on the same edge as a fall acceptance -> evt_sticky[1]=1.
//      - clr_evt[1]=1 next cycle -> 0.
//   5. Reset mid-filter:
//      - src[2] 0->1, drop rst_n for 1 cycle when cnt=2.
//      - Expect no pulse, gen[2]=0 at reset; gen[2]=1 exactly 6 edges after release.
//   6. FILT_CNT=1 build:
//      - Toggle src[0] every 2 cycles.
//      - Expect gen[0] to track with 2-edge latency, with alternating rise/fall pulses.

Source files
------------

// File: rtl/bb_sync_filter_if.sv
// Channel bundle for bb_sync_filter: async level inputs, sticky clears and the
// filtered level / edge-event outputs.
interface bb_sync_filter_if #(
  parameter int unsigned CH_NUM = 4
);
  logic [CH_NUM-1:0] src_signal;
  logic [CH_NUM-1:0] clr_evt;
  logic [CH_NUM-1:0] gen_signal;
  logic [CH_NUM-1:0] rise_pulse;
  logic [CH_NUM-1:0] fall_pulse;
  logic [CH_NUM-1:0] evt_sticky;

  modport master (
    output src_signal,
    output clr_evt,
    input  gen_signal,
    input  rise_pulse,
    input  fall_pulse,
    input  evt_sticky
  );

  modport slave (
    input  src_signal,
    input  clr_evt,
    output gen_signal,
    output rise_pulse,
    output fall_pulse,
    output evt_sticky
  );
endinterface

// File: rtl/bb_sync_filter.sv
// Multi-channel level synchroniser: flop chain, per-channel stability filter,
// registered clean level with coincident rise/fall pulses and a sticky change flag.
module bb_sync_filter #(
  parameter int unsigned        CH_NUM    = 4,
  parameter int unsigned        STAGE_NUM = 2,
  parameter int unsigned        FILT_CNT  = 4,
  parameter logic [CH_NUM-1:0]  RST_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  bb_sync_filter_if.slave  bus
);

  localparam int unsigned       CW      = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0]     CntLast = CW'(FILT_CNT - 1);

  logic [CH_NUM-1:0] sync_q [STAGE_NUM];
  logic [CH_NUM-1:0] synced;

  logic [CW-1:0]     cnt_q [CH_NUM];
  logic [CW-1:0]     cnt_d [CH_NUM];
  logic [CH_NUM-1:0] accept;

  logic [CH_NUM-1:0] gen_q,  gen_d;
  logic [CH_NUM-1:0] rise_q, rise_d;
  logic [CH_NUM-1:0] fall_q, fall_d;
  logic [CH_NUM-1:0] evt_q,  evt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < STAGE_NUM; j++) begin
        sync_q[j] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= bus.src_signal;
      for (int unsigned j = 1; j < STAGE_NUM; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
    end
  end

  assign synced = sync_q[STAGE_NUM-1];

  // Counter tracks how long the synced value has disagreed with gen; any agreement zeroes it.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      cnt_d[i] = '0;
      if (synced[i] != gen_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // An accepted channel always takes the synced value, so the pulse direction is that value.
  always_comb begin
    gen_d  = gen_q ^ accept;
    rise_d = accept & synced;
    fall_d = accept & ~synced;
    evt_d  = accept | (evt_q & ~bus.clr_evt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_q  <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      gen_q  <= gen_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.gen_signal = gen_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.evt_sticky = evt_q;

endmodule

// File: tb/tb_bb_sync_filter.sv
// Bench for bb_sync_filter: hand-built vector table, a FILT_CNT=1 toggle sequence and
// randomized traffic checked against a window-based reference model.
module tb_bb_sync_filter;

  localparam logic [3:0] RstVal = 4'b0010;
  localparam int         Stg    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] src = 4'h0;
  logic [3:0] clr = 4'h0;

  always #5 clk = ~clk;

  bb_sync_filter_if #(.CH_NUM(4)) bus_a ();
  bb_sync_filter_if #(.CH_NUM(4)) bus_b ();

  assign bus_a.src_signal = src;
  assign bus_a.clr_evt    = clr;
  assign bus_b.src_signal = src;
  assign bus_b.clr_evt    = clr;

  bb_sync_filter #(
    .CH_NUM(4), .STAGE_NUM(2), .FILT_CNT(4), .RST_VAL(RstVal)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  bb_sync_filter #(
    .CH_NUM(4), .STAGE_NUM(2), .FILT_CNT(1), .RST_VAL(RstVal)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %b exp %b", name, got, exp);
  endtask

  // Reference model: s at an edge is the src seen STAGE edges earlier (RstVal if that
  // predates reset); a channel accepts when the last FILT s values all differ from gen.
  int         filt [2] = '{4, 1};
  logic [3:0] hist [2][8];
  int         hist_n [2];
  logic [3:0] slog [2][8];
  int         slog_n [2];
  logic [3:0] m_gen [2], m_rise [2], m_fall [2], m_stk [2];

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_gen[d] = RstVal; m_rise[d] = '0; m_fall[d] = '0; m_stk[d] = '0;
        hist_n[d] = 0; slog_n[d] = 0;
      end else begin
        logic [3:0] s, acc;
        s = (hist_n[d] >= Stg) ? hist[d][Stg-1] : RstVal;
        for (int j = 7; j > 0; j--) slog[d][j] = slog[d][j-1];
        slog[d][0] = s;
        if (slog_n[d] < 8) slog_n[d]++;
        for (int c = 0; c < 4; c++) begin
          acc[c] = (slog_n[d] >= filt[d]);
          for (int j = 0; j < filt[d]; j++)
            if (slog[d][j][c] == m_gen[d][c]) acc[c] = 1'b0;
        end
        m_rise[d] = acc & s;
        m_fall[d] = acc & ~s;
        m_gen[d]  = m_gen[d] ^ acc;
        m_stk[d]  = acc | (m_stk[d] & ~clr);
        for (int j = 7; j > 0; j--) hist[d][j] = hist[d][j-1];
        hist[d][0] = src;
        if (hist_n[d] < 8) hist_n[d]++;
      end
    end
  endtask

  task automatic check_model();
    chk("model_a_gen",  bus_a.gen_signal, m_gen[0]);
    chk("model_a_rise", bus_a.rise_pulse, m_rise[0]);
    chk("model_a_fall", bus_a.fall_pulse, m_fall[0]);
    chk("model_a_stk",  bus_a.evt_sticky, m_stk[0]);
    chk("model_b_gen",  bus_b.gen_signal, m_gen[1]);
    chk("model_b_rise", bus_b.rise_pulse, m_rise[1]);
    chk("model_b_fall", bus_b.fall_pulse, m_fall[1]);
    chk("model_b_stk",  bus_b.evt_sticky, m_stk[1]);
  endtask

  task automatic step(input logic r, input logic [3:0] s, input logic [3:0] c);
    rst_n = r; src = s; clr = c;
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] src;
    logic [3:0] clr;
    logic [3:0] gen;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] stk;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input logic r, input logic [3:0] s, input logic [3:0] c,
                     input logic [3:0] g, input logic [3:0] ri, input logic [3:0] fa,
                     input logic [3:0] st);
    vec_t v;
    v.rst = r; v.src = s; v.clr = c; v.gen = g; v.rise = ri; v.fall = fa; v.stk = st;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  initial begin
    logic [3:0] rs;
    logic       app [16];
    logic       prev;

    // Reset hold with all-high inputs, then release: nothing may move for 5 edges.
    add(3, 0, 4'hF, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    add(5, 1, 4'hF, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    // Clean rise on ch0.
    add(5, 1, 4'h3, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    add(1, 1, 4'h3, 4'h0, 4'h3, 4'h1, 4'h0, 4'h1);
    add(1, 1, 4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 4'h1);
    add(1, 1, 4'h3, 4'h1, 4'h3, 4'h0, 4'h0, 4'h0);
    // ch3: 3-cycle glitch rejected, 4-cycle pulse passes.
    add(3, 1, 4'hB, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0);
    add(5, 1, 4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0);
    add(4, 1, 4'hB, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0);
    add(1, 1, 4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0);
    add(1, 1, 4'h3, 4'h0, 4'hB, 4'h8, 4'h0, 4'h8);
    add(3, 1, 4'h3, 4'h0, 4'hB, 4'h0, 4'h0, 4'h8);
    add(1, 1, 4'h3, 4'h0, 4'h3, 4'h0, 4'h8, 4'h8);
    add(1, 1, 4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 4'h8);
    add(1, 1, 4'h3, 4'h8, 4'h3, 4'h0, 4'h0, 4'h0);
    // ch1 fall: clear coincident with acceptance loses, next-cycle clear wins.
    add(5, 1, 4'h1, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0);
    add(1, 1, 4'h1, 4'h2, 4'h1, 4'h0, 4'h2, 4'h2);
    add(1, 1, 4'h1, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    // ch2 rise interrupted by reset at cnt=2, then full latency after release.
    add(4, 1, 4'h5, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'h5, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    add(5, 1, 4'h5, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    add(1, 1, 4'h5, 4'h0, 4'h5, 4'h5, 4'h2, 4'h7);
    add(1, 1, 4'h5, 4'h0, 4'h5, 4'h0, 4'h0, 4'h7);
    add(1, 1, 4'h5, 4'hF, 4'h5, 4'h0, 4'h0, 4'h0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].src, vq[i].clr);
      chk($sformatf("row%0d_gen",  i), bus_a.gen_signal, vq[i].gen);
      chk($sformatf("row%0d_rise", i), bus_a.rise_pulse, vq[i].rise);
      chk($sformatf("row%0d_fall", i), bus_a.fall_pulse, vq[i].fall);
      chk($sformatf("row%0d_stk",  i), bus_a.evt_sticky, vq[i].stk);
    end

    // FILT_CNT=1: gen[0] follows src[0] two edges later with alternating pulses.
    step(1'b0, 4'h0, 4'h0);
    for (int t = 0; t < 16; t++) begin
      app[t] = ((t / 2) % 2) == 1;
      step(1'b1, {3'b000, app[t]}, 4'h0);
      if (t >= 2) begin
        prev = (t >= 3) ? app[t-3] : 1'b0;
        chk($sformatf("f1_gen_t%0d", t),  {3'b0, bus_b.gen_signal[0]}, {3'b0, app[t-2]});
        chk($sformatf("f1_rise_t%0d", t), {3'b0, bus_b.rise_pulse[0]}, {3'b0, app[t-2] & ~prev});
        chk($sformatf("f1_fall_t%0d", t), {3'b0, bus_b.fall_pulse[0]}, {3'b0, ~app[t-2] & prev});
      end
    end

    // Randomized traffic: sparse flips so some changes survive the filter.
    rs = 4'h0;
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(4) == 0) rs[c] = ~rs[c];
      step(($urandom_range(63) != 0),
           rs,
           ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
